// File: rtl/knap_pkg.sv
// knap_pkg: shared definitions for the knapsack solver front-end.
//   state_t  - loader FSM states
//   status_t - result status codes returned on res_status
//   KNAP_MAX_N - default maximum item count
package knap_pkg;

  localparam int unsigned KNAP_MAX_N = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BADHDR  = 2'd1,
    ST_SOLVERR = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_t;

  // A header is unusable when it announces no items or more than the
  // solver can hold.
  function automatic logic hdr_bad(input logic [3:0] n, input int unsigned max_n);
    return (n == 4'd0) || (32'(n) > max_n);
  endfunction

endpackage

// File: rtl/knap_loader.sv
// knap_loader: byte-serial front-end for the knapsack solver.
// Collects one header beat {N, W} and N item beats {weight, profit},
// packs them into the solver operands, pulses R_I, waits for R_O (or a
// timeout) and presents the selection mask and a status code.
//
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   in_valid/in_ready     - input beat handshake, in_data carries the beat
//   N, W, w, p            - solver operands (item i in nibble [4i+3:4i])
//   R_I                   - one-cycle solver start strobe
//   out, R_O, Error       - solver result mask, done flag, error flag
//   res_valid/res_ready   - result handshake
//   res_sel, res_status   - latched mask and status (0 ok, 1 bad header,
//                           2 solver error, 3 timeout)
module knap_loader
  import knap_pkg::*;
#(
  parameter int unsigned MAX_N   = KNAP_MAX_N,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic [3:0]         N,
  output logic [3:0]         W,
  output logic [4*MAX_N-1:0] w,
  output logic [4*MAX_N-1:0] p,
  output logic               R_I,
  input  logic [0:MAX_N-1]   out,
  input  logic               R_O,
  input  logic               Error,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [0:MAX_N-1]   res_sel,
  output logic [1:0]         res_status
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [3:0]    k;
  logic [TW-1:0] cnt;

  always_comb begin
    in_ready = (state == IDLE) || (state == LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      N          <= '0;
      W          <= '0;
      w          <= '0;
      p          <= '0;
      R_I        <= 1'b0;
      res_valid  <= 1'b0;
      res_sel    <= '0;
      res_status <= ST_OK;
      k          <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            N <= in_data[7:4];
            W <= in_data[3:0];
            w <= '0;
            p <= '0;
            k <= '0;
            if (hdr_bad(in_data[7:4], MAX_N)) begin
              res_sel    <= '0;
              res_status <= ST_BADHDR;
              res_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < MAX_N; i++) begin
              if (k == 4'(i)) begin
                w[4*i +: 4] <= in_data[7:4];
                p[4*i +: 4] <= in_data[3:0];
              end
            end
            k <= k + 4'd1;
            if (k == N - 4'd1) begin
              R_I   <= 1'b1;
              cnt   <= '0;
              state <= START;
            end
          end
        end

        // The counter measures cycles since the strobe, so the START cycle
        // itself already counts as one.
        START: begin
          R_I   <= 1'b0;
          cnt   <= cnt + 1'b1;
          state <= WAIT;
        end

        WAIT: begin
          cnt <= cnt + 1'b1;
          if (R_O) begin
            res_sel    <= out;
            res_status <= Error ? ST_SOLVERR : ST_OK;
            res_valid  <= 1'b1;
            state      <= DONE;
          end else if (cnt >= TW'(TIMEOUT - 1)) begin
            res_sel    <= '0;
            res_status <= ST_TIMEOUT;
            res_valid  <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
